// File: rtl/car_request_conditioner.sv
// Car-sensor request conditioner: synchronise, debounce and hold a button press as a request
// until acknowledged. Optional pending-press counter enabled with `define CAR_REQ_COUNT_EN.
module car_request_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int DB_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_raw,
  input  logic       ack,
  output logic       car,
  output logic       car_pulse,
  output logic       btn_stable
`ifdef CAR_REQ_COUNT_EN
  ,
  output logic [3:0] req_count
`endif
);

  localparam logic [DB_W-1:0] LP_DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ARMWAIT = 2'd2
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_stable;
  logic            r_btn_prev;
  state_t          r_state;
  logic            r_car;
  logic            r_car_pulse;

  state_t          w_state_next;
  logic            w_press;
  logic            w_ack_accept;
  logic            w_car_d;
  logic            w_pulse_d;

  // Synchroniser and debounce: btn_stable follows sync_out only after DB_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_db_cnt     <= '0;
      r_btn_stable <= 1'b0;
      r_btn_prev   <= 1'b0;
    end else begin
      r_sync1    <= car_raw;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_btn_stable;
      if (r_sync2 == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == LP_DB_LAST) begin
        r_btn_stable <= r_sync2;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_press      = r_btn_stable & ~r_btn_prev;
  assign w_ack_accept = (r_state == ST_PENDING) & ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_car       <= 1'b0;
      r_car_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_car       <= w_car_d;
      r_car_pulse <= w_pulse_d;
    end
  end

  // ARMWAIT blocks re-arming until the held button is released
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press) w_state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (ack) w_state_next = r_btn_stable ? ST_ARMWAIT : ST_IDLE;
      end
      ST_ARMWAIT: begin
        if (!r_btn_stable) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so car/car_pulse are glitch-free
  always_comb begin
    w_car_d   = (w_state_next == ST_PENDING);
    w_pulse_d = w_car_d & (r_state != ST_PENDING);
  end

  assign car        = r_car;
  assign car_pulse  = r_car_pulse;
  assign btn_stable = r_btn_stable;

`ifdef CAR_REQ_COUNT_EN
  logic [3:0] r_req_count;

  // An accepted ack clears the count even if a press lands in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_count <= 4'd0;
    end else if (w_ack_accept) begin
      r_req_count <= 4'd0;
    end else if (w_press && (r_state != ST_ARMWAIT) && (r_req_count != 4'hF)) begin
      r_req_count <= r_req_count + 4'd1;
    end
  end

  assign req_count = r_req_count;
`else
  logic w_unused;
  assign w_unused = w_ack_accept;
`endif

endmodule

// File: tb/tb_car_request_conditioner.sv
// Directed bench for car_request_conditioner (DB_CYCLES=8): reset, debounce, ack handshakes,
// merges, mid-request reset, bounce rejection and the optional press counter.
module tb_car_request_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_raw;
  logic       ack;
  logic       car;
  logic       car_pulse;
  logic       btn_stable;
`ifdef CAR_REQ_COUNT_EN
  logic [3:0] req_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  car_request_conditioner #(.DB_CYCLES(8), .DB_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .car_raw    (car_raw),
    .ack        (ack),
    .car        (car),
    .car_pulse  (car_pulse),
    .btn_stable (btn_stable)
`ifdef CAR_REQ_COUNT_EN
    ,
    .req_count  (req_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit so outputs can be sampled
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; car_raw = 1'b1; ack = 1'b1;
    step(2);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_override: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    car_raw = 1'b0; ack = 1'b0;
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
`ifdef CAR_REQ_COUNT_EN
    n_checks++;
    if (req_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: req_count=%0d expected 0", req_count);
    end
`endif
  endtask

  task automatic test_clean_press;
    reset = 1'b1; car_raw = 1'b1;
    step(9);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL press_edge9: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL press_edge10: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b111) begin
      n_fail++;
      $display("FAIL press_edge11: {car,pulse,stable}=%b expected 111", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b101) begin
      n_fail++;
      $display("FAIL press_edge12: {car,pulse,stable}=%b expected 101", {car, car_pulse, btn_stable});
    end
    step(5);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b101) begin
      n_fail++;
      $display("FAIL press_hold: {car,pulse,stable}=%b expected 101", {car, car_pulse, btn_stable});
    end
  endtask

  task automatic test_ack_held;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL ack_held_drop: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    for (int k = 0; k < 3; k++) begin
      step(2);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      n_checks++;
      if ({car, car_pulse, btn_stable} !== 3'b001) begin
        n_fail++;
        $display("FAIL ack_held_extra%0d: {car,pulse,stable}=%b expected 001", k, {car, car_pulse, btn_stable});
      end
    end
    car_raw = 1'b0;
    step(9);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL release_edge9: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL release_edge10: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    step(2);
    car_raw = 1'b1;
    step(10);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL repress_edge10: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b111) begin
      n_fail++;
      $display("FAIL repress_edge11: {car,pulse,stable}=%b expected 111", {car, car_pulse, btn_stable});
    end
  endtask

  task automatic test_ack_after_release;
    car_raw = 1'b0;
    step(10);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b100) begin
      n_fail++;
      $display("FAIL released_pending: {car,pulse,stable}=%b expected 100", {car, car_pulse, btn_stable});
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL ack_released_drop: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    car_raw = 1'b1;
    step(10);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL newpress_edge10: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b111) begin
      n_fail++;
      $display("FAIL newpress_edge11: {car,pulse,stable}=%b expected 111", {car, car_pulse, btn_stable});
    end
  endtask

  task automatic test_simultaneous;
    car_raw = 1'b0;
    step(10);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL sim_setup_idle: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    car_raw = 1'b1;
    step(10);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b111) begin
      n_fail++;
      $display("FAIL press_with_ack: {car,pulse,stable}=%b expected 111", {car, car_pulse, btn_stable});
    end
  endtask

  task automatic test_back_to_back;
    car_raw = 1'b0;
    step(10);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b100) begin
      n_fail++;
      $display("FAIL merge_release: {car,pulse,stable}=%b expected 100", {car, car_pulse, btn_stable});
    end
    step(2);
    car_raw = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step(1);
      n_checks++;
      if ({car, car_pulse} !== 2'b10) begin
        n_fail++;
        $display("FAIL merge_cycle%0d: {car,pulse}=%b expected 10", k, {car, car_pulse});
      end
    end
  endtask

  task automatic test_midop_reset;
    reset = 1'b0;
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_reset: {car,pulse,stable}=%b expected 000", {car, car_pulse, btn_stable});
    end
    reset = 1'b1;
    step(10);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b001) begin
      n_fail++;
      $display("FAIL held_reset_edge10: {car,pulse,stable}=%b expected 001", {car, car_pulse, btn_stable});
    end
    step(1);
    n_checks++;
    if ({car, car_pulse, btn_stable} !== 3'b111) begin
      n_fail++;
      $display("FAIL held_reset_edge11: {car,pulse,stable}=%b expected 111", {car, car_pulse, btn_stable});
    end
  endtask

  task automatic test_bounce;
    car_raw = 1'b0;
    step(10);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(3);
    car_raw = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      n_checks++;
      if ({car, car_pulse, btn_stable} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_hi5_%0d: {car,pulse,stable}=%b expected 000", k, {car, car_pulse, btn_stable});
      end
    end
    car_raw = 1'b0;
    step(1);
    car_raw = 1'b1;
    step(3);
    car_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      n_checks++;
      if ({car, car_pulse, btn_stable} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_tail%0d: {car,pulse,stable}=%b expected 000", k, {car, car_pulse, btn_stable});
      end
    end
  endtask

`ifdef CAR_REQ_COUNT_EN
  task automatic test_req_count;
    logic [5:0] exp_v [3];
    exp_v[0] = 6'b11_0001;
    exp_v[1] = 6'b10_0010;
    exp_v[2] = 6'b10_0011;
    for (int k = 0; k < 3; k++) begin
      car_raw = 1'b1;
      step(11);
      n_checks++;
      if ({car, car_pulse, req_count} !== exp_v[k]) begin
        n_fail++;
        $display("FAIL count_press%0d: {car,pulse,count}=%b expected %b", k, {car, car_pulse, req_count}, exp_v[k]);
      end
      if (k < 2) begin
        car_raw = 1'b0;
        step(11);
      end
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_checks++;
    if ({car, req_count} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL count_ack: {car,count}=%b expected 00000", {car, req_count});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; car_raw = 1'b0; ack = 1'b0;
    test_reset;
    test_clean_press;
    test_ack_held;
    test_ack_after_release;
    test_simultaneous;
    test_back_to_back;
    test_midop_reset;
    test_bounce;
`ifdef CAR_REQ_COUNT_EN
    test_req_count;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
